// File: rtl/write_addr_window_fifo_pkg.sv
// Shared write-path definitions: address composition, FIFO entry layout and
// window slot bit-offset helpers.
`ifndef ROW_ADDR_BITS
`define ROW_ADDR_BITS 14
`endif
`ifndef COL_ADDR_BITS
`define COL_ADDR_BITS 10
`endif
`ifndef BANK_ADDR_BITS
`define BANK_ADDR_BITS 3
`endif

package write_addr_window_fifo_pkg;

   // Full write address width, packed as {bank, row, col}.
   localparam int WADDR_W = `ROW_ADDR_BITS + `COL_ADDR_BITS + `BANK_ADDR_BITS;

   // One FIFO entry: valid bit above the address.
   typedef struct packed {
      logic               valid;
      logic [WADDR_W-1:0] addr;
   } waddr_entry_t;

   // LSB position of window slot `slot` in a flattened window of
   // (addr_w+1)-bit entries.
   function automatic int slot_lsb(input int slot, input int addr_w);
      return slot * (addr_w + 1);
   endfunction

   // Width needed to index n slots, never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/write_addr_window_fifo_match.sv
// Combinational address compare across the window slots with a
// youngest-first priority pick (highest slot index wins).
module addr_match_window
   import write_addr_window_fifo_pkg::*;
#(
   parameter int ADDR_W = WADDR_W,
   parameter int WIN    = 8,
   localparam int IDX_W = idx_width(WIN)
) (
   input  logic [WIN*(ADDR_W+1)-1:0] win,
   input  logic [ADDR_W-1:0]         lk_addr,
   output logic                      hit,
   output logic [IDX_W-1:0]          hit_idx
);

   logic [ADDR_W:0] entry;

   // Scan oldest to newest so the last match seen is the youngest one.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      entry   = '0;
      for (int k = 0; k < WIN; k++) begin
         entry = win[slot_lsb(k, ADDR_W) +: ADDR_W+1];
         if (entry[ADDR_W] && (entry[ADDR_W-1:0] == lk_addr)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/write_addr_window_fifo.sv
// Pending-write address FIFO with a sliding window over the newest entries,
// occupancy/status flags and a registered read-after-write lookup port.
module write_addr_window_fifo
   import write_addr_window_fifo_pkg::*;
#(
   parameter int ADDR_W     = WADDR_W,
   parameter int DEPTH_LOG2 = 4,
   parameter int WIN        = 8,
   localparam int IDX_W     = idx_width(WIN)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [ADDR_W-1:0]         i_data,
   input  logic                      i_wr_en,
   input  logic                      i_rd_en,
   input  logic                      i_flush,
   input  logic                      i_lk_en,
   input  logic [ADDR_W-1:0]         i_lk_addr,
   output logic [ADDR_W:0]           o_head,
   output logic [WIN*(ADDR_W+1)-1:0] o_win,
   output logic [DEPTH_LOG2:0]       o_count,
   output logic                      o_full,
   output logic                      o_empty,
   output logic                      o_hit,
   output logic [IDX_W-1:0]          o_hit_idx
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;

   logic [ADDR_W:0]           mem [DEPTH];
   logic [PW-1:0]             wr_ptr, rd_ptr;
   logic [PW-1:0]             wr_nxt, rd_nxt;
   logic                      push, pop, clear;
   logic [WIN*(ADDR_W+1)-1:0] win_nxt;
   logic [DEPTH_LOG2-1:0]     nxt_idx;
   logic [ADDR_W:0]           nxt_entry;
   logic                      m_hit;
   logic [IDX_W-1:0]          m_idx;

   // Memory index shown in window slot k for a given write pointer; wraps
   // modulo the depth so the window may straddle the end of the array.
   function automatic logic [DEPTH_LOG2-1:0] win_index(input logic [PW-1:0] ptr,
                                                       input int k);
      return ptr[DEPTH_LOG2-1:0] - DEPTH_LOG2'(WIN) + DEPTH_LOG2'(k);
   endfunction

   assign clear = i_rst || i_flush;
   assign push  = i_wr_en && !o_full;
   assign pop   = i_rd_en && !o_empty;

   // Next-state pointers; reset and flush both drop any push or pop.
   always_comb begin
      wr_nxt = wr_ptr;
      rd_nxt = rd_ptr;
      if (clear) begin
         wr_nxt = '0;
         rd_nxt = '0;
      end else begin
         if (push) wr_nxt = wr_ptr + PW'(1);
         if (pop)  rd_nxt = rd_ptr + PW'(1);
      end
   end

   // Storage, pointers and registered status flags.
   always_ff @(posedge i_clk) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_count <= '0;
         o_full  <= 1'b0;
         o_empty <= 1'b1;
      end else begin
         // Push and pop never target the same slot, so both writes are safe.
         if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {1'b1, i_data};
         if (pop)  mem[rd_ptr[DEPTH_LOG2-1:0]] <= '0;
         wr_ptr  <= wr_nxt;
         rd_ptr  <= rd_nxt;
         o_count <= wr_nxt - rd_nxt;
         o_full  <= (wr_nxt ^ rd_nxt) == {1'b1, {DEPTH_LOG2{1'b0}}};
         o_empty <= (wr_nxt == rd_nxt);
      end
   end

   // Visible window, read straight from registered storage.
   always_comb begin
      o_win = '0;
      for (int k = 0; k < WIN; k++) begin
         o_win[slot_lsb(k, ADDR_W) +: ADDR_W+1] = mem[win_index(wr_ptr, k)];
      end
   end

   assign o_head = mem[rd_ptr[DEPTH_LOG2-1:0]];

   // Window as it will stand after this cycle's update, so a lookup sees a
   // same-cycle push and does not see a same-cycle popped entry.
   always_comb begin
      win_nxt   = '0;
      nxt_idx   = '0;
      nxt_entry = '0;
      for (int k = 0; k < WIN; k++) begin
         nxt_idx   = win_index(wr_nxt, k);
         nxt_entry = mem[nxt_idx];
         if (push && (nxt_idx == wr_ptr[DEPTH_LOG2-1:0])) begin
            nxt_entry = {1'b1, i_data};
         end else if (pop && (nxt_idx == rd_ptr[DEPTH_LOG2-1:0])) begin
            nxt_entry = '0;
         end
         if (clear) nxt_entry = '0;
         win_nxt[slot_lsb(k, ADDR_W) +: ADDR_W+1] = nxt_entry;
      end
   end

   addr_match_window #(
      .ADDR_W (ADDR_W),
      .WIN    (WIN)
   ) u_match (
      .win     (win_nxt),
      .lk_addr (i_lk_addr),
      .hit     (m_hit),
      .hit_idx (m_idx)
   );

   // Lookup result register; index is forced to 0 whenever there is no hit.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_hit     <= 1'b0;
         o_hit_idx <= '0;
      end else begin
         o_hit     <= i_lk_en && m_hit;
         o_hit_idx <= (i_lk_en && m_hit) ? m_idx : '0;
      end
   end

endmodule

// File: tb/tb_write_addr_window_fifo.sv
// Randomised and directed bench for write_addr_window_fifo against a
// push-history reference model.
module tb_write_addr_window_fifo;
   import write_addr_window_fifo_pkg::*;

   localparam int AW    = WADDR_W;
   localparam int DL    = 4;
   localparam int DEPTH = 2 ** DL;
   localparam int WIN   = 8;
   localparam int IW    = idx_width(WIN);

   typedef logic [AW-1:0] addr_t;

   logic                   clk = 1'b0;
   logic                   i_rst = 1'b1;
   logic [AW-1:0]          i_data = '0;
   logic                   i_wr_en = 1'b0;
   logic                   i_rd_en = 1'b0;
   logic                   i_flush = 1'b0;
   logic                   i_lk_en = 1'b0;
   logic [AW-1:0]          i_lk_addr = '0;
   logic [AW:0]            o_head;
   logic [WIN*(AW+1)-1:0]  o_win;
   logic [DL:0]            o_count;
   logic                   o_full, o_empty, o_hit;
   logic [IW-1:0]          o_hit_idx;

   write_addr_window_fifo #(.ADDR_W(AW), .DEPTH_LOG2(DL), .WIN(WIN)) dut (
      .i_clk     (clk),
      .i_rst     (i_rst),
      .i_data    (i_data),
      .i_wr_en   (i_wr_en),
      .i_rd_en   (i_rd_en),
      .i_flush   (i_flush),
      .i_lk_en   (i_lk_en),
      .i_lk_addr (i_lk_addr),
      .o_head    (o_head),
      .o_win     (o_win),
      .o_count   (o_count),
      .o_full    (o_full),
      .o_empty   (o_empty),
      .o_hit     (o_hit),
      .o_hit_idx (o_hit_idx)
   );

   always #5 clk = ~clk;

   // Reference model: every address pushed since the last flush/reset, in
   // order, plus how many of them have been retired.
   addr_t hist[$];
   int    pops;
   bit    exp_hit;
   int    exp_idx;
   int    tests;
   int    fails;
   addr_t pool[5];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic waddr_entry_t model_slot(input int k);
      waddr_entry_t e;
      int p;
      e = '0;
      p = hist.size() - WIN + k;
      if (p >= 0 && p >= pops) begin
         e.valid = 1'b1;
         e.addr  = hist[p];
      end
      return e;
   endfunction

   function automatic logic [WIN*(AW+1)-1:0] model_win();
      logic [WIN*(AW+1)-1:0] w;
      w = '0;
      for (int k = 0; k < WIN; k++) w[slot_lsb(k, AW) +: AW+1] = model_slot(k);
      return w;
   endfunction

   task automatic check_all();
      int cnt;
      logic [AW:0] head;
      cnt  = hist.size() - pops;
      head = (cnt > 0) ? {1'b1, hist[pops]} : '0;
      chk("count", o_count, cnt);
      chk("full",  o_full,  cnt == DEPTH);
      chk("empty", o_empty, cnt == 0);
      chk("head",  o_head,  head);
      chk("win",   o_win,   model_win());
      chk("hit",   o_hit,   exp_hit);
      chk("hit_idx", o_hit_idx, exp_idx);
   endtask

   task automatic step(input bit rst, input bit wr, input bit rd, input bit fl,
                       input bit lk, input addr_t d, input addr_t la);
      int cnt;
      waddr_entry_t e;
      i_rst = rst; i_wr_en = wr; i_rd_en = rd; i_flush = fl;
      i_lk_en = lk; i_data = d; i_lk_addr = la;
      @(posedge clk);
      cnt = hist.size() - pops;
      if (rst || fl) begin
         hist.delete();
         pops = 0;
      end else begin
         if (wr && cnt < DEPTH) hist.push_back(d);
         if (rd && cnt > 0) pops++;
      end
      exp_hit = 1'b0;
      exp_idx = 0;
      if (!rst && lk) begin
         for (int k = 0; k < WIN; k++) begin
            e = model_slot(k);
            if (e.valid && e.addr == la) begin
               exp_hit = 1'b1;
               exp_idx = k;
            end
         end
      end
      #1;
      check_all();
   endtask

   task automatic push(input addr_t d);
      step(0, 1, 0, 0, 0, d, '0);
   endtask

   addr_t a[8];
   addr_t x, b;

   initial begin
      tests = 0; fails = 0; pops = 0;
      for (int i = 0; i < 5; i++) pool[i] = addr_t'($urandom());
      for (int i = 0; i < 8; i++) a[i] = addr_t'($urandom());
      x = addr_t'($urandom());
      b = addr_t'($urandom());

      step(1, 0, 0, 0, 0, '0, '0);
      step(1, 0, 0, 0, 0, '0, '0);
      chk("reset_empty", o_empty, 1'b1);
      chk("reset_win", o_win, '0);

      // Eight pushes, then window corners and head.
      for (int i = 0; i < 8; i++) push(a[i]);
      chk("a_count", o_count, 8);
      chk("a_slot7", o_win[slot_lsb(7, AW) +: AW+1], {1'b1, a[7]});
      chk("a_slot0", o_win[slot_lsb(0, AW) +: AW+1], {1'b1, a[0]});
      chk("a_head", o_head, {1'b1, a[0]});

      // Fill, overflow attempt, pop+push at full, then wrap the pointers.
      for (int i = 0; i < 8; i++) push(pool[i % 5]);
      chk("fill_full", o_full, 1'b1);
      push(x);
      chk("ovf_count", o_count, 16);
      step(0, 1, 1, 0, 0, b, '0);
      chk("full_pp_count", o_count, 15);
      push(b);
      chk("refull", o_full, 1'b1);
      for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 1, pool[i % 5], pool[(i + 2) % 5]);

      // Three copies of X, oldest retired: youngest copy wins.
      step(0, 0, 0, 1, 0, '0, '0);
      push(x); push(x); push(x);
      step(0, 0, 1, 0, 0, '0, '0);
      step(0, 0, 0, 0, 1, '0, x);
      chk("x_hit", o_hit, 1'b1);
      chk("x_idx", o_hit_idx, 7);
      step(0, 0, 1, 0, 0, '0, '0);
      step(0, 0, 1, 0, 0, '0, '0);
      step(0, 0, 0, 0, 1, '0, x);
      chk("x_gone", o_hit, 1'b0);

      // Same-cycle push and lookup.
      step(0, 1, 0, 0, 1, b, b);
      chk("b_hit", o_hit, 1'b1);
      chk("b_idx", o_hit_idx, WIN - 1);

      // Push, pop and flush together at half full.
      for (int i = 0; i < 7; i++) push(pool[i % 5]);
      step(0, 1, 1, 1, 1, pool[0], pool[0]);
      chk("fl_empty", o_empty, 1'b1);
      chk("fl_count", o_count, 0);
      chk("fl_win", o_win, '0);
      chk("fl_hit", o_hit, 1'b0);

      // Reset while full with a lookup in flight.
      for (int i = 0; i < DEPTH; i++) push(pool[i % 5]);
      step(0, 0, 0, 0, 1, '0, pool[1]);
      chk("pre_rst_hit", o_hit, 1'b1);
      step(1, 1, 1, 0, 1, pool[1], pool[1]);
      chk("rst_hit", o_hit, 1'b0);
      chk("rst_full", o_full, 1'b0);
      chk("rst_head", o_head, '0);
      chk("rst_win", o_win, '0);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 99) < 60,
              $urandom_range(0, 99) < 45,
              $urandom_range(0, 99) < 2,
              $urandom_range(0, 1) == 1,
              pool[$urandom_range(0, 4)],
              pool[$urandom_range(0, 4)]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
